cp0_irq: RTL and testbench

CP0_IRQ -- requirements
Module: cp0_irq

---
 rtl/cp0_irq_if.sv | 32 +++
 rtl/cp0_irq.sv | 166 ++++++++++++++++
 tb/tb_cp0_irq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_irq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_irq_if
//  Description : CP0 access and interrupt/jump signal bundle between the
//                pipeline (master) and the interrupt controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_irq_if #(
    parameter int N_IRQ = 8
);
    logic [1:0]       oper;
    logic [4:0]       addr_r;
    logic [31:0]      data_r;
    logic [4:0]       addr_w;
    logic [31:0]      data_w;
    logic             ir_en;
    logic [N_IRQ-1:0] ir_in;
    logic [31:0]      ret_addr;
    logic             jump_en;
    logic [31:0]      jump_addr;

    modport master (
        output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        input  data_r, jump_en, jump_addr
    );

    modport slave (
        input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        output data_r, jump_en, jump_addr
    );
endinterface
`default_nettype wire

// File: rtl/cp0_irq.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_irq
//  Description : CP0 interrupt controller. Edge-detected external interrupts,
//                STATUS/CAUSE/EPC/EHBR registers, fixed-priority selection,
//                single or vectored handler entry, ERET return.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_irq #(
    parameter int N_IRQ     = 8,
    parameter int VEC_MODE  = 0,
    parameter int VEC_SHIFT = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    cp0_irq_if.slave   bus
);
    localparam logic [1:0] c_op_mtc0    = 2'b01;
    localparam logic [1:0] c_op_eret    = 2'b10;
    localparam logic [4:0] c_addr_status = 5'd12;
    localparam logic [4:0] c_addr_cause  = 5'd13;
    localparam logic [4:0] c_addr_epc    = 5'd14;
    localparam logic [4:0] c_addr_ehbr   = 5'd15;

    // Registered state
    logic             r_ie_q,      w_ie_d;
    logic             r_exl_q,     w_exl_d;
    logic [N_IRQ-1:0] r_im_q,      w_im_d;
    logic [N_IRQ-1:0] r_pending_q, w_pending_d;
    logic [N_IRQ-1:0] r_ir_prev_q, w_ir_prev_d;
    logic [4:0]       r_exc_id_q,  w_exc_id_d;
    logic [31:0]      r_epc_q,     w_epc_d;
    logic [31:0]      r_ehbr_q,    w_ehbr_d;
    logic [31:0]      r_data_r_q,  w_data_r_d;

    // Decode, priority select and jump generation
    logic             w_is_mtc0;
    logic             w_is_eret;
    logic [N_IRQ-1:0] w_cand;
    logic [N_IRQ-1:0] w_win;
    logic [4:0]       w_id;
    logic             w_take;
    logic [31:0]      w_vec_addr;
    logic             w_jump_en;
    logic [31:0]      w_jump_addr;
    logic [N_IRQ-1:0] w_edge;
    logic [31:0]      w_status_rd;
    logic [31:0]      w_cause_rd;

    // Lowest-index unmasked pending line wins; jump path sees only state, oper, ir_en
    always_comb begin
        w_is_mtc0 = (bus.oper == c_op_mtc0);
        w_is_eret = (bus.oper == c_op_eret);
        w_cand    = r_pending_q & r_im_q;
        w_id      = '0;
        w_win     = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_id     = 5'(i);
                w_win    = '0;
                w_win[i] = 1'b1;
            end
        end
        w_take = ~rst & bus.ir_en & r_ie_q & ~r_exl_q & (|w_cand)
               & ~w_is_eret & ~w_is_mtc0;
        w_vec_addr  = r_ehbr_q + (32'(w_id) << VEC_SHIFT);
        w_jump_en   = 1'b0;
        w_jump_addr = '0;
        if (!rst) begin
            if (w_is_eret) begin
                w_jump_en   = 1'b1;
                w_jump_addr = r_epc_q;
            end else if (w_take) begin
                w_jump_en   = 1'b1;
                w_jump_addr = (VEC_MODE != 0) ? w_vec_addr : r_ehbr_q;
            end
        end
    end

    // Next-state: register writes, take/ERET side effects, edge capture, readback
    always_comb begin
        w_ie_d      = r_ie_q;
        w_exl_d     = r_exl_q;
        w_im_d      = r_im_q;
        w_exc_id_d  = r_exc_id_q;
        w_epc_d     = r_epc_q;
        w_ehbr_d    = r_ehbr_q;
        w_ir_prev_d = bus.ir_in;
        w_edge      = bus.ir_in & ~r_ir_prev_q;

        if (w_is_mtc0) begin
            case (bus.addr_w)
                c_addr_status: begin
                    w_ie_d  = bus.data_w[0];
                    w_exl_d = bus.data_w[1];
                    w_im_d  = bus.data_w[8 +: N_IRQ];
                end
                c_addr_epc:  w_epc_d  = bus.data_w;
                c_addr_ehbr: w_ehbr_d = {bus.data_w[31:2], 2'b00};
                default: ;
            endcase
        end

        // Clear sources first so a same-cycle rising edge re-sets the bit
        w_pending_d = r_pending_q;
        if (w_is_mtc0 && (bus.addr_w == c_addr_cause)) begin
            w_pending_d = w_pending_d & ~bus.data_w[8 +: N_IRQ];
        end
        if (w_take) begin
            w_pending_d = w_pending_d & ~w_win;
            w_exl_d     = 1'b1;
            w_exc_id_d  = w_id;
            w_epc_d     = bus.ret_addr;
        end
        if (w_is_eret) begin
            w_exl_d = 1'b0;
        end
        w_pending_d = w_pending_d | w_edge;

        w_status_rd              = '0;
        w_status_rd[0]           = r_ie_q;
        w_status_rd[1]           = r_exl_q;
        w_status_rd[8 +: N_IRQ]  = r_im_q;
        w_cause_rd               = '0;
        w_cause_rd[8 +: N_IRQ]   = r_pending_q;
        w_cause_rd[6:2]          = r_exc_id_q;

        case (bus.addr_r)
            c_addr_status: w_data_r_d = w_status_rd;
            c_addr_cause:  w_data_r_d = w_cause_rd;
            c_addr_epc:    w_data_r_d = r_epc_q;
            c_addr_ehbr:   w_data_r_d = r_ehbr_q;
            default:       w_data_r_d = '0;
        endcase
    end

    // State update with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie_q      <= 1'b0;
            r_exl_q     <= 1'b0;
            r_im_q      <= '0;
            r_pending_q <= '0;
            r_ir_prev_q <= '0;
            r_exc_id_q  <= '0;
            r_epc_q     <= '0;
            r_ehbr_q    <= '0;
            r_data_r_q  <= '0;
        end else begin
            r_ie_q      <= w_ie_d;
            r_exl_q     <= w_exl_d;
            r_im_q      <= w_im_d;
            r_pending_q <= w_pending_d;
            r_ir_prev_q <= w_ir_prev_d;
            r_exc_id_q  <= w_exc_id_d;
            r_epc_q     <= w_epc_d;
            r_ehbr_q    <= w_ehbr_d;
            r_data_r_q  <= w_data_r_d;
        end
    end

    assign bus.data_r    = r_data_r_q;
    assign bus.jump_en   = w_jump_en;
    assign bus.jump_addr = w_jump_addr;
endmodule
`default_nettype wire

// File: tb/tb_cp0_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_irq
//  Description : Directed vector bench for cp0_irq; one instance in single
//                handler mode and one in vectored mode share the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_irq;
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] MTC = 2'b01;
    localparam logic [1:0] ERT = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_irq_if #(.N_IRQ(8)) bus0 ();
    cp0_irq_if #(.N_IRQ(8)) bus1 ();

    cp0_irq #(.N_IRQ(8), .VEC_MODE(0), .VEC_SHIFT(4)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    cp0_irq #(.N_IRQ(8), .VEC_MODE(1), .VEC_SHIFT(4)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    assign bus1.oper     = bus0.oper;
    assign bus1.addr_r   = bus0.addr_r;
    assign bus1.addr_w   = bus0.addr_w;
    assign bus1.data_w   = bus0.data_w;
    assign bus1.ir_en    = bus0.ir_en;
    assign bus1.ir_in    = bus0.ir_in;
    assign bus1.ret_addr = bus0.ret_addr;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic        en;
        logic [7:0]  irq;
        logic [31:0] ra;
        logic [4:0]  ar;
        logic        je;
        logic [31:0] ja0;
        logic [31:0] ja1;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(logic r, logic [1:0] op, logic [4:0] aw, logic [31:0] dw,
                                logic en, logic [7:0] irq, logic [31:0] ra, logic [4:0] ar,
                                logic je, logic [31:0] ja0, logic [31:0] ja1, logic [31:0] rd);
        vec_t v;
        v.rst = r;  v.op = op;   v.aw = aw;   v.dw = dw;  v.en = en; v.irq = irq;
        v.ra = ra;  v.ar = ar;   v.je = je;   v.ja0 = ja0; v.ja1 = ja1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] op, input logic [4:0] aw,
                         input logic [31:0] dw, input logic en, input logic [7:0] irq,
                         input logic [31:0] ra, input logic [4:0] ar);
        rst           = r;
        bus0.oper     = op;
        bus0.addr_w   = aw;
        bus0.data_w   = dw;
        bus0.ir_en    = en;
        bus0.ir_in    = irq;
        bus0.ret_addr = ra;
        bus0.addr_r   = ar;
    endtask

    // Called right after inputs are applied at a falling edge
    task automatic check_cycle(input string tag, input logic je, input logic [31:0] ja0,
                               input logic [31:0] ja1, input logic [31:0] rd);
        #1;
        chk({tag, " je0"}, 32'(bus0.jump_en), 32'(je));
        chk({tag, " je1"}, 32'(bus1.jump_en), 32'(je));
        chk({tag, " ja0"}, bus0.jump_addr, ja0);
        chk({tag, " ja1"}, bus1.jump_addr, ja1);
        @(posedge clk);
        #1;
        chk({tag, " rd0"}, bus0.data_r, rd);
        chk({tag, " rd1"}, bus1.data_r, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        drive(1'b1, NOP, 5'd0, 32'd0, 1'b0, 8'h00, 32'd0, 5'd0);

        //         rst  op   aw     dw            en  irq    ra        ar     je  ja0        ja1        rd
        // reset and post-reset readback
        tbl.push_back(mk(1, NOP, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(1, ERT, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd14, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        0, 8'h00, 32'h0,   5'd15, 0, 32'h0,     32'h0,     32'h0));
        // configure: EHBR low bits forced 0, no write bypass on read
        tbl.push_back(mk(0, MTC, 5'd15, 32'h103,      0, 8'h00, 32'h0,   5'd15, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, MTC, 5'd12, 32'h0000FF01, 0, 8'h00, 32'h0,   5'd15, 0, 32'h0,     32'h0,     32'h100));
        // single interrupt on line 3
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h08, 32'h40,  5'd12, 0, 32'h0,     32'h0,     32'h0000FF01));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h08, 32'h40,  5'd13, 1, 32'h100,   32'h130,   32'h800));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h08, 32'h40,  5'd13, 0, 32'h0,     32'h0,     32'h0C));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h08, 32'h40,  5'd14, 0, 32'h0,     32'h0,     32'h40));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h08, 32'h40,  5'd12, 0, 32'h0,     32'h0,     32'hFF03));
        // no nesting: line 0 accumulates while EXL=1
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h09, 32'h40,  5'd12, 0, 32'h0,     32'h0,     32'hFF03));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h09, 32'h40,  5'd13, 0, 32'h0,     32'h0,     32'h10C));
        tbl.push_back(mk(0, ERT, 5'd0,  32'h0,        1, 8'h09, 32'h80,  5'd14, 1, 32'h40,    32'h40,    32'h40));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h09, 32'h80,  5'd13, 1, 32'h100,   32'h100,   32'h10C));
        tbl.push_back(mk(0, ERT, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd14, 1, 32'h80,    32'h80,    32'h80));
        // priority and vectoring: lines 5 and 2 together
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h24, 32'h200, 5'd13, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h24, 32'h200, 5'd13, 1, 32'h100,   32'h120,   32'h2400));
        tbl.push_back(mk(0, ERT, 5'd0,  32'h0,        1, 8'h24, 32'h300, 5'd13, 1, 32'h200,   32'h200,   32'h2008));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h24, 32'h300, 5'd14, 1, 32'h100,   32'h150,   32'h200));
        tbl.push_back(mk(0, ERT, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd13, 1, 32'h300,   32'h300,   32'h14));
        // ERET with EXL already clear still jumps
        tbl.push_back(mk(0, ERT, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd12, 1, 32'h300,   32'h300,   32'hFF01));
        // masking of line 1 and write-1-to-clear
        tbl.push_back(mk(0, MTC, 5'd12, 32'h0000FD01, 1, 8'h00, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'hFF01));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h02, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'hFD01));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h02, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, MTC, 5'd13, 32'h200,      1, 8'h02, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h14));
        // set wins over same-cycle clear
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h02, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h14));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, MTC, 5'd13, 32'h200,      1, 8'h02, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h02, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, MTC, 5'd13, 32'h200,      1, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h214));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h14));
        // ir_en gating, then MTC0 defers a take by one cycle
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h10, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h14));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        0, 8'h10, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h1014));
        tbl.push_back(mk(0, MTC, 5'd14, 32'h500,      1, 8'h10, 32'h600, 5'd14, 0, 32'h0,     32'h0,     32'h300));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h10, 32'h600, 5'd14, 1, 32'h100,   32'h140,   32'h500));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h10, 32'h600, 5'd14, 0, 32'h0,     32'h0,     32'h600));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h10, 32'h600, 5'd12, 0, 32'h0,     32'h0,     32'hFD03));
        // reset in the middle of a handler
        tbl.push_back(mk(1, NOP, 5'd0,  32'h0,        1, 8'h01, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(1, ERT, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd14, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd12, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd13, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd14, 0, 32'h0,     32'h0,     32'h0));
        tbl.push_back(mk(0, NOP, 5'd0,  32'h0,        1, 8'h00, 32'h0,   5'd15, 0, 32'h0,     32'h0,     32'h0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].op, tbl[i].aw, tbl[i].dw, tbl[i].en,
                  tbl[i].irq, tbl[i].ra, tbl[i].ar);
            check_cycle($sformatf("v%0d", i), tbl[i].je, tbl[i].ja0, tbl[i].ja1, tbl[i].rd);
        end

        // Vectored target wraps modulo 2^32
        @(negedge clk); drive(0, MTC, 5'd15, 32'hFFFF_FFF0, 0, 8'h00, 32'h0, 5'd15);
        check_cycle("wrap_ehbr", 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); drive(0, MTC, 5'd12, 32'h0000_FF01, 0, 8'h00, 32'h0, 5'd15);
        check_cycle("wrap_status", 0, 32'h0, 32'h0, 32'hFFFF_FFF0);
        @(negedge clk); drive(0, NOP, 5'd0, 32'h0, 1, 8'h02, 32'h44, 5'd13);
        check_cycle("wrap_edge", 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); drive(0, NOP, 5'd0, 32'h0, 1, 8'h02, 32'h44, 5'd13);
        check_cycle("wrap_take", 1, 32'hFFFF_FFF0, 32'h0, 32'h200);
        @(negedge clk); drive(0, NOP, 5'd0, 32'h0, 1, 8'h02, 32'h0, 5'd14);
        check_cycle("wrap_epc", 0, 32'h0, 32'h0, 32'h44);

        // oper 2'b11 behaves as nop: no register write, no jump
        @(negedge clk); drive(0, 2'b11, 5'd12, 32'h0, 1, 8'h02, 32'h0, 5'd12);
        check_cycle("op11_a", 0, 32'h0, 32'h0, 32'hFF03);
        @(negedge clk); drive(0, NOP, 5'd0, 32'h0, 1, 8'h02, 32'h0, 5'd12);
        check_cycle("op11_b", 0, 32'h0, 32'h0, 32'hFF03);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
